// File: rtl/formant_dp_engine.sv
// formant_dp_engine: pipelined F(k,i)/B(k,i) min-plus recurrence for one frame, one request per cycle.
module formant_dp_engine #(
  parameter int BIT_WIDTH    = 32,
  parameter int I            = 160,
  parameter int FORMANTS     = 5,
  parameter int READ_LATENCY = 2,
  parameter int MIN_SEG      = 1,
  parameter int TIE_MODE     = 0
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  begin_iter,
  input  logic        [$clog2(I)-1:0]           i,
  input  logic signed [BIT_WIDTH-1:0]           e_prev,
  input  logic signed [BIT_WIDTH-1:0]           f_prev,
  output logic                                  req_valid,
  output logic        [$clog2(FORMANTS+1)-1:0]  k_req,
  output logic signed [$clog2(I):0]             j_req,
  output logic        [$clog2(FORMANTS+1)-1:0]  k_write,
  output logic signed [BIT_WIDTH-1:0]           f_data,
  output logic signed [$clog2(I):0]             b_data,
  output logic                                  output_valid,
  output logic                                  iter_done,
  output logic                                  busy
);
  localparam int IW = $clog2(I);
  localparam int KW = $clog2(FORMANTS + 1);
  localparam int JW = IW + 1;
  localparam int BW = BIT_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam logic signed [BW-1:0] INF = {2'b00, {(BW-2){1'b1}}};
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic        [IW-1:0] r_i;
  logic        [KW-1:0] r_k, r_kmax, r_kw;
  logic signed [JW-1:0] r_j, r_ab, r_b;
  logic signed [BW-1:0] r_af, r_f;
  logic                 r_ov;
  logic                 r_tv [RL];
  logic                 r_tf [RL];
  logic                 r_tl [RL];
  logic        [KW-1:0] r_tk [RL];
  logic signed [JW-1:0] r_tj [RL];
  logic signed [IW+1:0] w_kcap;
  logic        [KW-1:0] w_kmax, w_tk;
  logic signed [JW-1:0] w_jend, w_kbase, w_tj, w_tbase, w_bb, w_nb;
  logic signed [BW:0]   w_sum;
  logic signed [BW-1:0] w_sat, w_cost, w_bf, w_nf;
  logic                 w_none, w_last_j, w_last_k, w_first, w_tv, w_tf, w_tl, w_jneg, w_upd;
  assign w_kcap   = $signed({2'b00, i}) + $signed((IW+2)'(2 - MIN_SEG));
  assign w_none   = w_kcap < $signed((IW+2)'(1));
  assign w_kmax   = (w_kcap > $signed((IW+2)'(FORMANTS))) ? KW'(FORMANTS) : KW'(w_kcap);
  assign w_jend   = $signed({1'b0, r_i}) - $signed(JW'(MIN_SEG));
  assign w_kbase  = $signed(JW'(r_k)) - $signed(JW'(2));
  assign w_last_j = r_j == w_jend;
  assign w_last_k = r_k == r_kmax;
  assign w_first  = r_j == w_kbase;
  // Oldest tag lines up with the e_prev/f_prev returned for that request
  assign w_tv    = r_tv[RL-1];
  assign w_tf    = r_tf[RL-1];
  assign w_tl    = r_tl[RL-1];
  assign w_tk    = r_tk[RL-1];
  assign w_tj    = r_tj[RL-1];
  assign w_tbase = $signed(JW'(w_tk)) - $signed(JW'(2));
  assign w_jneg  = w_tj[JW-1];
  assign w_sum   = {e_prev[BW-1], e_prev} + {f_prev[BW-1], f_prev};
  assign w_sat   = (w_sum > $signed({1'b0, INF})) ? INF : w_sum[BW-1:0];
  assign w_cost  = (w_tk == KW'(1)) ? (w_jneg ? e_prev : INF) : (w_jneg ? INF : w_sat);
  assign w_bf    = w_tf ? INF : r_af;
  assign w_bb    = w_tf ? w_tbase : r_ab;
  assign w_upd   = (TIE_MODE != 0) ? (w_cost <= w_bf && w_cost != INF) : (w_cost < w_bf);
  assign w_nf    = w_upd ? w_cost : w_bf;
  assign w_nb    = w_upd ? w_tj : w_bb;
  always_ff @(posedge clk_in)
    if (rst_in) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:    w_next = begin_iter ? (w_none ? DONE : ISSUE) : IDLE;
      ISSUE:   w_next = (w_last_j && w_last_k) ? DRAIN : ISSUE;
      DRAIN:   w_next = (w_tv && w_tl && w_tk == r_kmax) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_valid = r_state == ISSUE;
    busy      = r_state == ISSUE || r_state == DRAIN;
    iter_done = r_state == DONE;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_i    <= '0;
      r_k    <= '0;
      r_kmax <= '0;
      r_j    <= '0;
      r_af   <= '0;
      r_ab   <= '0;
      r_ov   <= 1'b0;
      r_kw   <= '0;
      r_f    <= '0;
      r_b    <= '0;
      for (int s = 0; s < RL; s++) r_tv[s] <= 1'b0;
    end else begin
      if (r_state == IDLE && begin_iter) begin
        r_i    <= i;
        r_kmax <= w_kmax;
        r_k    <= KW'(1);
        r_j    <= -$signed(JW'(1));
      end else if (r_state == ISSUE) begin
        r_k <= r_k + KW'(w_last_j && !w_last_k);
        r_j <= w_last_j ? $signed(JW'(r_k)) - $signed(JW'(1)) : r_j + $signed(JW'(1));
      end
      r_tv[0] <= r_state == ISSUE;
      r_tk[0] <= r_k;
      r_tj[0] <= r_j;
      r_tf[0] <= w_first;
      r_tl[0] <= w_last_j;
      for (int s = 1; s < RL; s++) begin
        r_tv[s] <= r_tv[s-1];
        r_tk[s] <= r_tk[s-1];
        r_tj[s] <= r_tj[s-1];
        r_tf[s] <= r_tf[s-1];
        r_tl[s] <= r_tl[s-1];
      end
      if (w_tv) begin
        r_af <= w_nf;
        r_ab <= w_nb;
      end
      r_ov <= w_tv && w_tl;
      if (w_tv && w_tl) begin
        r_kw <= w_tk;
        r_f  <= w_nf;
        r_b  <= w_nb;
      end
    end
  end
  assign k_req        = r_k;
  assign j_req        = r_j;
  assign k_write      = r_kw;
  assign f_data       = r_f;
  assign b_data       = r_b;
  assign output_valid = r_ov;
endmodule

// File: doc/formant_dp_engine.md
Name: formant_dp_engine

Overview:
- Parametrised, fully pipelined successor to the per-i F/B recurrence engine in the formant tracker.
- For one frame index i it computes F(k,i) = min over j of E(j+1,i) + F(k-1,j), and the backpointer B(k,i), for every legal k.
- Requests for consecutive k are issued back to back, with no bubble. Memory read latency, minimum segment length and tie-break are parameters.
- Sits between the Emin/F/B memories and the tracker control FSM, which pulses begin_iter once E(·,i) is complete.

Parameters:
- BIT_WIDTH, 32, width of cost words, signed.
- I, 160, number of frames; i ranges 0..I-1.
- FORMANTS, 5, maximum k.
- READ_LATENCY, 2, cycles from a request to e_prev/f_prev valid; range 1..4.
- MIN_SEG, 1, minimum segment length; j ranges up to i-MIN_SEG; range 1..8.
- TIE_MODE, 0, on equal cost: 0 keeps the earliest j, 1 keeps the latest j.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- begin_iter  in  1  start pulse; sampled only in IDLE.
- i  in  $clog2(I)  frame index; latched on an accepted begin_iter.
- e_prev  in  BIT_WIDTH  E(j+1,i), READ_LATENCY cycles after the request.
- f_prev  in  BIT_WIDTH  F(k-1,j), READ_LATENCY cycles after the request.
- req_valid  out  1  k_req/j_req are a live request this cycle.
- k_req  out  $clog2(FORMANTS+1)  requested k.
- j_req  out  $clog2(I)+1  requested j, signed; may be -1.
- k_write  out  $clog2(FORMANTS+1)  k of the result.
- f_data  out  BIT_WIDTH  F(k,i).
- b_data  out  $clog2(I)+1  B(k,i), signed.
- output_valid  out  1  one-cycle strobe; result fields are valid.
- iter_done  out  1  one-cycle pulse; iteration for i is finished.
- busy  out  1  high from acceptance of begin_iter until iter_done.

Behaviour:
- Reset: all outputs 0, state IDLE, pipeline tags cleared. Reset mid-operation aborts with no further output_valid or iter_done.
- INF = 2^(BIT_WIDTH-2)-1. Inputs lie in 0..INF.
- Sum = e_prev + f_prev, computed at BIT_WIDTH+1 bits and saturated to INF.
- Legal k: 1..KMAX, where KMAX = min(FORMANTS, i+2-MIN_SEG). If KMAX < 1, there are no k.
- For each k, j runs k-2 .. i-MIN_SEG ascending, one request per cycle.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
  - IDLE: on begin_iter, latch i, assert busy, go to ISSUE. If KMAX < 1, go straight to DONE instead: iter_done is high the cycle after begin_iter, output_valid never pulses.
  - ISSUE: one request per cycle with req_valid=1. After the last j of k, the next cycle issues j=k-1 for k+1, with no gap. After the last request of KMAX, go to DRAIN with req_valid=0.
  - DRAIN: wait for the in-flight responses, then return to IDLE.
- Each request carries a tag (k, j, first, last) down a READ_LATENCY-deep shift register. The tag is aligned with the returned e_prev/f_prev.
- Candidate for a response:
  - k=1, j=-1: cost = e_prev, because F(0,-1)=0.
  - k=1, j>=0: cost = INF, because F(0,j)=INF.
  - k>1, j=-1: cost = INF.
  - Otherwise: cost = saturated sum.
- Accumulator initialisation: on a first-tagged response, the accumulator starts from (INF, k-2) before the compare.
- Update rule:
  - TIE_MODE=0: replace when cost is strictly less than the accumulator.
  - TIE_MODE=1: replace when cost is less than or equal, but never replace with an INF cost.
- Result: on a last-tagged response at cycle t, at t+1 output_valid=1 with k_write=k, f_data=final min, b_data=argmin j. Results for consecutive k may appear in consecutive cycles.
- iter_done: pulses in the same cycle as the output_valid for KMAX. busy drops in that same cycle, and the next begin_iter is accepted in the following cycle.
- begin_iter while busy is ignored.
- Latency: last request at cycle r gives output_valid at r+READ_LATENCY+1.

Test Plan:
1. Defaults, i=0, e_prev=7. Expect exactly one request (k=1, j=-1), then output_valid with k_write=1, f_data=7, b_data=-1, iter_done in the same cycle, 4 cycles after begin_iter.
2. i=3, E(j+1,3) for j=-1..2 = 9,4,6,2.
   - k=1: F(1,3)=9, B=-1.
   - k=2, F(1,j) for j=0,1,2 = 3,1,8: sums 7,7,10, so F(2,3)=7, B=0.
   - Expected: 9 requests for k=1..3 with no gaps; KMAX=min(5,4)=4, so k=4 is also issued.
3. Case 2 with TIE_MODE=1: expect F(2,3)=7 with B=1.
4. e_prev=INF-1, f_prev=10 on every candidate for k=2: expect f_data=INF (0x3FFFFFFF) and b_data=0, which is k-2.
5. MIN_SEG=3:
   - i=1: expect no requests, iter_done the cycle after begin_iter, busy low afterwards.
   - i=2: expect a single request (k=1, j=-1).
6. Reset two cycles into case 2, then begin_iter again: expect no stale output_valid, and a full correct result sequence on the rerun. A begin_iter pulse issued mid-run must be ignored.
